// File: rtl/booth_mac_pipe.sv
// Pipelined radix-4 Booth multiplier-accumulator: Booth partial products (S1), CSA tree (S2),
// final carry-propagate add plus sticky-overflow accumulator (S3), with whole-pipe stall flow control.
module booth_mac_pipe #(
  parameter int WIDTH = 16,
  parameter int ACC_W = 2*WIDTH+8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               a_signed,
  input  logic               b_signed,
  input  logic               acc_clr,
  input  logic               acc_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic [ACC_W-1:0]   acc,
  output logic               acc_ovf
);

  localparam int P    = 2*WIDTH;
  localparam int NPP  = WIDTH/2 + 1;
  localparam int NROW = NPP + 2;
  localparam int MW   = WIDTH + 2;

  function automatic int rows_after(input int n);
    return 2*(n/3) + n%3;
  endfunction

  function automatic int rows_at(input int lvl);
    int n;
    n = NROW;
    for (int i = 0; i < lvl; i++) n = rows_after(n);
    return n;
  endfunction

  function automatic int num_levels();
    int n;
    int l;
    n = NROW;
    l = 0;
    while (n > 2) begin
      n = rows_after(n);
      l++;
    end
    return l;
  endfunction

  // Each partial product's sign bit is flipped; this constant restores -sum(2^(MW-1+2i)).
  function automatic logic [P-1:0] sep_const();
    logic [P-1:0] s;
    s = '0;
    for (int i = 0; i < NPP; i++) s = s + ({{(P-1){1'b0}}, 1'b1} << (MW-1+2*i));
    return ~s + {{(P-1){1'b0}}, 1'b1};
  endfunction

  localparam int           NLVL  = num_levels();
  localparam logic [P-1:0] SEP_K = sep_const();

  logic             stall_s;
  logic [WIDTH:0]   ax_s;
  logic [MW-1:0]    mag1_s, mag2_s, mag_s, ppv_s;
  logic [WIDTH+2:0] bx_s;
  logic             neg_s;
  logic [P+3:0]     wide_s;
  logic [P-1:0]     neg_row_s;
  logic [P-1:0]     rows_s [NROW];

  logic [P-1:0]     rows_r [NROW];
  logic             v1_r, clr1_r, en1_r, sg1_r;
  logic [P-1:0]     tree_s [NLVL+1][NROW];
  logic [P-1:0]     sum_r, carry_r;
  logic             v2_r, clr2_r, en2_r, sg2_r;

  logic [P-1:0]     p_s;
  logic [ACC_W-1:0] ext_s, add_s, acc_nxt_s;
  logic             add_ovf_s, ovf_nxt_s;
  logic [P-1:0]     product_r;
  logic [ACC_W-1:0] acc_r;
  logic             ovf_r, out_valid_r;

  assign stall_s   = out_valid_r & ~out_ready;
  assign in_ready  = ~stall_s;
  assign out_valid = out_valid_r;
  assign product   = product_r;
  assign acc       = acc_r;
  assign acc_ovf   = ovf_r;

  // S1 combinational: Booth-encode extended b and build pre-shifted partial-product rows.
  always_comb begin
    ax_s      = {a_signed & a[WIDTH-1], a};
    mag1_s    = {ax_s[WIDTH], ax_s};
    mag2_s    = {ax_s, 1'b0};
    bx_s      = {{2{b_signed & b[WIDTH-1]}}, b, 1'b0};
    neg_row_s = '0;
    mag_s     = '0;
    neg_s     = 1'b0;
    ppv_s     = '0;
    wide_s    = '0;
    for (int i = 0; i < NPP; i++) begin
      mag_s = '0;
      neg_s = 1'b0;
      case (bx_s[2*i+2 -: 3])
        3'b001, 3'b010: mag_s = mag1_s;
        3'b011:         mag_s = mag2_s;
        3'b100: begin
          mag_s = mag2_s;
          neg_s = 1'b1;
        end
        3'b101, 3'b110: begin
          mag_s = mag1_s;
          neg_s = 1'b1;
        end
        default: begin
          mag_s = '0;
          neg_s = 1'b0;
        end
      endcase
      ppv_s  = neg_s ? ~mag_s : mag_s;
      wide_s = {{(P+4-MW){1'b0}}, ~ppv_s[MW-1], ppv_s[MW-2:0]} << (2*i);
      rows_s[i]         = wide_s[P-1:0];
      neg_row_s[2*i]    = neg_s;
    end
    rows_s[NPP]   = neg_row_s;
    rows_s[NPP+1] = SEP_K;
  end

  // S1 register: partial-product rows plus beat control.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_r   <= 1'b0;
      clr1_r <= 1'b0;
      en1_r  <= 1'b0;
      sg1_r  <= 1'b0;
      for (int i = 0; i < NROW; i++) rows_r[i] <= '0;
    end else if (!stall_s) begin
      v1_r   <= in_valid;
      clr1_r <= acc_clr;
      en1_r  <= acc_en;
      sg1_r  <= a_signed | b_signed;
      rows_r <= rows_s;
    end
  end

  // Wallace reduction: each level compresses groups of three rows; leftovers pass through.
  for (genvar j = 0; j < NROW; j++) begin : g_l0
    assign tree_s[0][j] = rows_r[j];
  end

  for (genvar l = 0; l < NLVL; l++) begin : g_lvl
    localparam int NIN  = rows_at(l);
    localparam int NG   = NIN/3;
    localparam int NOUT = rows_after(NIN);
    for (genvar j = 0; j < NROW; j++) begin : g_row
      localparam int K = 3*(j/2);
      if (j < 2*NG && j%2 == 0) begin : g_sum
        assign tree_s[l+1][j] = tree_s[l][K] ^ tree_s[l][K+1] ^ tree_s[l][K+2];
      end else if (j < 2*NG) begin : g_cry
        assign tree_s[l+1][j] = ((tree_s[l][K] & tree_s[l][K+1]) |
                                 (tree_s[l][K] & tree_s[l][K+2]) |
                                 (tree_s[l][K+1] & tree_s[l][K+2])) << 1'b1;
      end else if (j < NOUT) begin : g_pass
        assign tree_s[l+1][j] = tree_s[l][j+NG];
      end else begin : g_zero
        assign tree_s[l+1][j] = '0;
      end
    end
  end

  // S2 register: carry-save sum and carry rows.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v2_r    <= 1'b0;
      clr2_r  <= 1'b0;
      en2_r   <= 1'b0;
      sg2_r   <= 1'b0;
      sum_r   <= '0;
      carry_r <= '0;
    end else if (!stall_s) begin
      v2_r    <= v1_r;
      clr2_r  <= clr1_r;
      en2_r   <= en1_r;
      sg2_r   <= sg1_r;
      sum_r   <= tree_s[NLVL][0];
      carry_r <= tree_s[NLVL][1];
    end
  end

  // S3 combinational: final add and accumulator next state.
  always_comb begin
    p_s       = sum_r + carry_r;
    ext_s     = {{(ACC_W-P){sg2_r & p_s[P-1]}}, p_s};
    add_s     = acc_r + ext_s;
    add_ovf_s = (acc_r[ACC_W-1] == ext_s[ACC_W-1]) && (add_s[ACC_W-1] != acc_r[ACC_W-1]);
    acc_nxt_s = acc_r;
    ovf_nxt_s = ovf_r;
    if (v2_r && clr2_r) begin
      acc_nxt_s = ext_s;
      ovf_nxt_s = 1'b0;
    end else if (v2_r && en2_r) begin
      acc_nxt_s = add_s;
      ovf_nxt_s = ovf_r | add_ovf_s;
    end else begin
      acc_nxt_s = acc_r;
      ovf_nxt_s = ovf_r;
    end
  end

  // S3 register: output beat, product and accumulator state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      product_r   <= '0;
      acc_r       <= '0;
      ovf_r       <= 1'b0;
    end else if (!stall_s) begin
      out_valid_r <= v2_r;
      product_r   <= v2_r ? p_s : product_r;
      acc_r       <= acc_nxt_s;
      ovf_r       <= ovf_nxt_s;
    end
  end

endmodule

// File: doc/booth_mac_pipe.md
Name: booth_mac_pipe

Overview:
Parametrised, pipelined radix-4 Booth multiplier-accumulator for the DSP datapath. Generalises the fixed 8x8 Booth/Wallace CSA multiplier to WIDTH x WIDTH with per-operand signedness, a registered 3-stage pipeline and an internal final carry-propagate add. It adds an optional accumulate mode with a sticky overflow flag, plus valid/ready flow control so it can sit between streaming filter stages.

Parameters:
WIDTH, 16, operand width; even, >= 4
ACC_W, 2*WIDTH+8, accumulator width; >= 2*WIDTH+1

Ports:
clk  in  1  system clock; all state on rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat
a  in  WIDTH  multiplicand
b  in  WIDTH  multiplier
a_signed  in  1  a is two's complement
b_signed  in  1  b is two's complement
acc_clr  in  1  beat starts a new accumulation (acc := product)
acc_en  in  1  beat adds product to accumulator
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts output
product  out  2*WIDTH  exact product of this beat
acc  out  ACC_W  accumulator value after this beat
acc_ovf  out  1  sticky signed overflow of accumulator

Behaviour:
- One clock domain. Asynchronous, active-high reset. Reset clears all stage valid bits, acc, acc_ovf and product to 0; out_valid=0 immediately on assertion.
- Pipeline, fixed latency 3 cycles (accept edge to out_valid):
  - S1: radix-4 Booth encode of b, extended by 2 bits (sign-extended if b_signed, else zero-extended), giving WIDTH/2+1 partial products.
  - S1: partial products generated from a, sign/zero-extended per a_signed, with negate correction bits and sign-extension-prevention constants. Registered.
  - S2: Wallace/Dadda CSA reduction to two 2*WIDTH rows (sum, carry). Registered.
  - S3: carry-propagate add gives product; accumulator update. Registered.
- Arithmetic: product is exact, mod 2^(2*WIDTH). It is interpreted as signed if a_signed|b_signed, else unsigned. Mixed signedness is supported (e.g. signed a x unsigned b).
- Accumulator, on each S3 load:
  - acc_clr=1: acc := ext(product); acc_ovf := 0. acc_clr takes priority over acc_en.
  - acc_clr=0, acc_en=1: acc := acc + ext(product). acc_ovf := acc_ovf | signed overflow of that add (operand signs equal, result sign differs).
  - both 0: acc and acc_ovf hold.
  - ext() sign-extends if the product is signed, else zero-extends. Accumulator arithmetic is two's complement, ACC_W bits, wraps on overflow.
  - acc_clr/acc_en are captured with a/b and travel down the pipe.
- Flow control: stall = out_valid & ~out_ready; in_ready = ~stall.
  - Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
  - During stall, all stage registers, valid bits, acc and acc_ovf hold. No beat is lost, duplicated or reordered.
  - Bubbles are not squeezed: the whole pipe freezes.
  - Throughput is 1 beat/cycle while out_ready=1.
- product/acc/acc_ovf are stable while out_valid=1 and stalled. Their values when out_valid=0 are don't-care, except after reset (0).
- in_valid=0 inserts a bubble; stage valid bit = 0 and no accumulator update.
- Reset mid-operation: all in-flight beats are discarded. First beat accepted after reset release appears 3 cycles later.

Test Plan:
- WIDTH=8, a=0x80, b=0x80, both signed, acc_clr=1 -> out_valid 3 cycles after accept; product=0x4000, acc=16384, acc_ovf=0.
- WIDTH=8, a=0xFF, b=0xFF, both unsigned -> product=0xFE01. Then a=0xFF signed, b=0xFF unsigned -> product=0xFF01 (-255).
- Accumulate, WIDTH=8: beat1 a=100, b=3, acc_clr=1; beat2 a=0xF9 (-7), b=5, both signed, acc_en=1 -> acc=300 then 265.
- Overflow, WIDTH=8, ACC_W=17: a=b=0x7F signed; acc_clr then 4x acc_en -> acc after 5th beat wraps (80645-131072=-50427), acc_ovf=1. acc_ovf stays 1 on a later acc_en beat and clears on the next acc_clr beat.
- Back-to-back 6 random beats, out_ready=0 for 2 cycles mid-stream -> in_ready=0 during stall, outputs held stable, all 6 results in order and matching the reference model, no duplicates.
- Reset asserted asynchronously with 3 beats in flight -> out_valid, acc, acc_ovf drop to 0 without a clock edge. Next beat after release emerges after exactly 3 cycles.
